aes_round_seq: RTL and testbench

Iterative AES round sequencer that drives a one-round-per-cycle AES engine inside the AES HWPE. Software starts a job through the control slave registers. The block then triggers key expansion and accepts plaintext/ciphertext blocks from the input streamer. It steps the datapath through the initial AddRoundKey and Nr rounds, hands results to the output streamer, and pulses a done event after the programmed number of blocks.

---
 rtl/aes_round_seq.sv | 133 +++++++++++++
 tb/tb_aes_round_seq.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/aes_round_seq.sv
// Round sequencer for an iterative one-round-per-cycle AES datapath.
// It runs key expansion, block intake, Nr rounds and result hand-off for a job of n blocks.
module aes_round_seq #(
   parameter int unsigned N_BLOCKS_W = 16
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  clear_i,
   input  logic                  start_i,
   input  logic [1:0]            key_len_i,
   input  logic                  decrypt_i,
   input  logic [N_BLOCKS_W-1:0] n_blocks_i,
   output logic                  ks_start_o,
   input  logic                  ks_done_i,
   input  logic                  in_valid_i,
   output logic                  in_ready_o,
   output logic                  dp_load_o,
   output logic                  dp_round_en_o,
   output logic [3:0]            dp_round_o,
   output logic                  dp_last_o,
   output logic                  dp_decrypt_o,
   output logic                  out_valid_o,
   input  logic                  out_ready_i,
   output logic                  busy_o,
   output logic                  done_o,
   output logic                  err_o,
   output logic [N_BLOCKS_W-1:0] blk_cnt_o
);

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_KEYEXP  = 3'd1;
   localparam logic [2:0] S_WAIT_IN = 3'd2;
   localparam logic [2:0] S_ROUND   = 3'd3;
   localparam logic [2:0] S_OUTPUT  = 3'd4;
   localparam logic [2:0] S_DONE    = 3'd5;

   logic [2:0]            state_q;
   logic [3:0]            rnd_q;
   logic [N_BLOCKS_W-1:0] blk_cnt_q;
   logic [N_BLOCKS_W-1:0] n_blocks_q;
   logic [1:0]            key_len_q;
   logic                  decrypt_q;
   logic                  ks_first_q;
   logic                  err_q;
   logic [3:0]            nr;
   logic [N_BLOCKS_W-1:0] blk_cnt_nxt;

   // Nr = 10 + 2*key_len; key_len never exceeds 2 once latched, so 4 bits suffice.
   assign nr          = 4'd10 + {1'b0, key_len_q, 1'b0};
   assign blk_cnt_nxt = blk_cnt_q + {{(N_BLOCKS_W-1){1'b0}}, 1'b1};

   always_ff @(posedge clk_i or negedge rst_ni) begin
      // NOTE: every register here uses non-blocking assignment so all updates see pre-edge values.
      if (!rst_ni) begin
         state_q    <= S_IDLE;
         rnd_q      <= 4'd0;
         blk_cnt_q  <= '0;
         n_blocks_q <= '0;
         key_len_q  <= 2'd0;
         decrypt_q  <= 1'b0;
         ks_first_q <= 1'b0;
         err_q      <= 1'b0;
      end else if (clear_i) begin
         state_q    <= S_IDLE;
         rnd_q      <= 4'd0;
         blk_cnt_q  <= '0;
         n_blocks_q <= '0;
         key_len_q  <= 2'd0;
         decrypt_q  <= 1'b0;
         ks_first_q <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         err_q      <= 1'b0;
         ks_first_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (start_i) begin
                  if (key_len_i == 2'd3) begin
                     err_q <= 1'b1;
                  end else begin
                     key_len_q  <= key_len_i;
                     decrypt_q  <= decrypt_i;
                     n_blocks_q <= n_blocks_i;
                     blk_cnt_q  <= '0;
                     if (n_blocks_i == '0) begin
                        state_q <= S_DONE;
                     end else begin
                        state_q    <= S_KEYEXP;
                        ks_first_q <= 1'b1;
                     end
                  end
               end
            end
            S_KEYEXP: begin
               if (ks_done_i) state_q <= S_WAIT_IN;
            end
            S_WAIT_IN: begin
               if (in_valid_i) begin
                  rnd_q   <= 4'd1;
                  state_q <= S_ROUND;
               end
            end
            S_ROUND: begin
               if (rnd_q == nr) state_q <= S_OUTPUT;
               else             rnd_q   <= rnd_q + 4'd1;
            end
            S_OUTPUT: begin
               if (out_ready_i) begin
                  blk_cnt_q <= blk_cnt_nxt;
                  state_q   <= (blk_cnt_nxt == n_blocks_q) ? S_DONE : S_WAIT_IN;
               end
            end
            S_DONE:  state_q <= S_IDLE;
            default: state_q <= S_IDLE;
         endcase
      end
   end

   // Everything is Moore-decoded except dp_load_o, which must coincide with the input handshake.
   assign ks_start_o    = (state_q == S_KEYEXP) & ks_first_q;
   assign in_ready_o    = (state_q == S_WAIT_IN);
   assign dp_load_o     = (state_q == S_WAIT_IN) & in_valid_i;
   assign dp_round_en_o = (state_q == S_ROUND);
   assign dp_round_o    = (state_q == S_ROUND) ? rnd_q : 4'd0;
   assign dp_last_o     = (state_q == S_ROUND) & (rnd_q == nr);
   assign dp_decrypt_o  = decrypt_q;
   assign out_valid_o   = (state_q == S_OUTPUT);
   assign busy_o        = (state_q != S_IDLE);
   assign done_o        = (state_q == S_DONE);
   assign err_o         = err_q;
   assign blk_cnt_o     = blk_cnt_q;

endmodule

// File: tb/tb_aes_round_seq.sv
// Self-checking bench for aes_round_seq: cycle-stepped job driver plus a block scoreboard.
module tb_aes_round_seq;

   localparam int NBW = 16;

   logic           clk_i = 1'b0;
   logic           rst_ni = 1'b0;
   logic           clear_i = 1'b0;
   logic           start_i = 1'b0;
   logic [1:0]     key_len_i = 2'd0;
   logic           decrypt_i = 1'b0;
   logic [NBW-1:0] n_blocks_i = '0;
   logic           ks_done_i = 1'b0;
   logic           in_valid_i = 1'b0;
   logic           out_ready_i = 1'b0;
   logic           ks_start_o, in_ready_o, dp_load_o, dp_round_en_o, dp_last_o, dp_decrypt_o;
   logic           out_valid_o, busy_o, done_o, err_o;
   logic [3:0]     dp_round_o;
   logic [NBW-1:0] blk_cnt_o;

   typedef struct {
      int   idx;
      logic dec;
      int   nr;
   } exp_t;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   aes_round_seq #(.N_BLOCKS_W(NBW)) dut (
      .clk_i(clk_i), .rst_ni(rst_ni), .clear_i(clear_i), .start_i(start_i),
      .key_len_i(key_len_i), .decrypt_i(decrypt_i), .n_blocks_i(n_blocks_i),
      .ks_start_o(ks_start_o), .ks_done_i(ks_done_i),
      .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
      .dp_load_o(dp_load_o), .dp_round_en_o(dp_round_en_o), .dp_round_o(dp_round_o),
      .dp_last_o(dp_last_o), .dp_decrypt_o(dp_decrypt_o),
      .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
      .busy_o(busy_o), .done_o(done_o), .err_o(err_o), .blk_cnt_o(blk_cnt_o)
   );

   always #5 clk_i = ~clk_i;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic logic [NBW+16:0] outs();
      return {ks_start_o, in_ready_o, dp_load_o, dp_round_en_o, dp_round_o, dp_last_o,
              dp_decrypt_o, out_valid_o, busy_o, done_o, err_o, blk_cnt_o};
   endfunction

   // stall_blk<0: no backpressure; clr_rnd>0: clear at that round of block 0;
   // start_rnd>0: stray start at that round of block 0; rst_out: reset in first output stall cycle.
   task automatic run_job(input logic [1:0] kl, input logic dec, input int n, input int ks_lat,
                          input int in_dly, input int stall_blk, input int stall_cyc,
                          input int clr_rnd, input int start_rnd, input bit rst_out,
                          input string tag);
      int   nr = 10 + 2 * int'(kl);
      int   rounds;
      int   stall;
      exp_t e;
      @(negedge clk_i);
      start_i = 1'b1; key_len_i = kl; decrypt_i = dec; n_blocks_i = n[NBW-1:0]; out_ready_i = 1'b0;
      for (int k = 0; k <= ks_lat; k++) begin
         @(negedge clk_i);
         start_i = 1'b0; ks_done_i = (k == ks_lat); #1;
         n_checks++; if (ks_start_o !== (k == 0)) begin n_fail++; $display("FAIL %s ks_start k=%0d got %b exp %b", tag, k, ks_start_o, k == 0); end
         n_checks++; if (busy_o !== 1'b1) begin n_fail++; $display("FAIL %s busy_keyexp got %b exp 1", tag, busy_o); end
      end
      for (int b = 0; b < n; b++) begin
         for (int w = 0; w <= in_dly; w++) begin
            @(negedge clk_i);
            ks_done_i = 1'b0; out_ready_i = 1'b0; in_valid_i = (w == in_dly); #1;
            n_checks++; if (in_ready_o !== 1'b1) begin n_fail++; $display("FAIL %s in_ready b=%0d w=%0d got %b exp 1", tag, b, w, in_ready_o); end
            n_checks++; if (dp_load_o !== in_valid_i) begin n_fail++; $display("FAIL %s dp_load b=%0d w=%0d got %b exp %b", tag, b, w, dp_load_o, in_valid_i); end
            if (in_valid_i) sb.push_back('{idx: b, dec: dec, nr: nr});
         end
         rounds = 0;
         for (int r = 1; r <= nr; r++) begin
            @(negedge clk_i);
            in_valid_i = 1'b0;
            start_i    = (b == 0 && r == start_rnd);
            key_len_i  = start_i ? 2'd3 : kl;
            clear_i    = (b == 0 && r == clr_rnd); #1;
            if (dp_round_en_o === 1'b1) rounds++;
            n_checks++; if (dp_round_o !== r[3:0]) begin n_fail++; $display("FAIL %s dp_round b=%0d got %0d exp %0d", tag, b, dp_round_o, r); end
            n_checks++; if (dp_last_o !== (r == nr)) begin n_fail++; $display("FAIL %s dp_last b=%0d r=%0d got %b exp %b", tag, b, r, dp_last_o, r == nr); end
            n_checks++; if (dp_decrypt_o !== dec) begin n_fail++; $display("FAIL %s dp_decrypt b=%0d r=%0d got %b exp %b", tag, b, r, dp_decrypt_o, dec); end
            n_checks++; if ({out_valid_o, in_ready_o, err_o} !== 3'b000) begin n_fail++; $display("FAIL %s round_side b=%0d r=%0d got %b exp 000", tag, b, r, {out_valid_o, in_ready_o, err_o}); end
            if (clear_i) begin
               @(negedge clk_i);
               clear_i = 1'b0; start_i = 1'b0; #1;
               n_checks++; if (outs() !== '0) begin n_fail++; $display("FAIL %s after_clear got %h exp 0", tag, outs()); end
               sb.delete();
               return;
            end
         end
         start_i = 1'b0;
         n_checks++; if (rounds !== nr) begin n_fail++; $display("FAIL %s round_count b=%0d got %0d exp %0d", tag, b, rounds, nr); end
         stall = (b == stall_blk) ? stall_cyc : 0;
         for (int s = 0; s <= stall; s++) begin
            @(negedge clk_i);
            start_i = 1'b0; out_ready_i = (s == stall); #1;
            n_checks++; if (out_valid_o !== 1'b1) begin n_fail++; $display("FAIL %s out_valid b=%0d s=%0d got %b exp 1", tag, b, s, out_valid_o); end
            n_checks++; if (dp_round_en_o !== 1'b0) begin n_fail++; $display("FAIL %s round_en_in_stall b=%0d got %b exp 0", tag, b, dp_round_en_o); end
            if (rst_out && s == 0 && !out_ready_i) begin
               #1 rst_ni = 1'b0; #1;
               n_checks++; if (outs() !== '0) begin n_fail++; $display("FAIL %s after_reset got %h exp 0", tag, outs()); end
               @(negedge clk_i);
               rst_ni = 1'b1; out_ready_i = 1'b0;
               sb.delete();
               return;
            end
            if (out_ready_i) begin
               if (sb.size() == 0) begin
                  n_checks++; n_fail++; $display("FAIL %s scoreboard_empty b=%0d got output exp none", tag, b);
               end else begin
                  e = sb.pop_front();
                  n_checks++; if (blk_cnt_o !== e.idx[NBW-1:0]) begin n_fail++; $display("FAIL %s blk_cnt_pre b=%0d got %0d exp %0d", tag, b, blk_cnt_o, e.idx); end
                  n_checks++; if (dp_decrypt_o !== e.dec) begin n_fail++; $display("FAIL %s out_decrypt b=%0d got %b exp %b", tag, b, dp_decrypt_o, e.dec); end
               end
            end
         end
      end
      @(negedge clk_i);
      out_ready_i = 1'b0; #1;
      n_checks++; if (done_o !== 1'b1) begin n_fail++; $display("FAIL %s done got %b exp 1", tag, done_o); end
      n_checks++; if (blk_cnt_o !== n[NBW-1:0]) begin n_fail++; $display("FAIL %s blk_cnt_final got %0d exp %0d", tag, blk_cnt_o, n); end
      @(negedge clk_i); #1;
      n_checks++; if ({done_o, busy_o} !== 2'b00) begin n_fail++; $display("FAIL %s post_done got %b exp 00", tag, {done_o, busy_o}); end
      n_checks++; if (blk_cnt_o !== n[NBW-1:0]) begin n_fail++; $display("FAIL %s blk_cnt_hold got %0d exp %0d", tag, blk_cnt_o, n); end
   endtask

   task automatic test_reset();
      #12;
      n_checks++; if (outs() !== '0) begin n_fail++; $display("FAIL reset outputs got %h exp 0", outs()); end
      @(negedge clk_i);
      rst_ni = 1'b1;
   endtask

   task automatic test_aes128();
      run_job(2'd0, 1'b0, 1, 1, 0, -1, 0, 0, 0, 1'b0, "aes128");
   endtask

   task automatic test_aes256_stall();
      run_job(2'd2, 1'b1, 3, 1, 0, 1, 5, 0, 0, 1'b0, "aes256");
   endtask

   task automatic test_aes192_delay();
      run_job(2'd1, 1'b0, 2, 2, 4, -1, 0, 0, 0, 1'b0, "aes192");
   endtask

   task automatic test_illegal_and_empty();
      int dones = 0;
      int ks    = 0;
      @(negedge clk_i);
      start_i = 1'b1; key_len_i = 2'd3; n_blocks_i = 16'd2; #1;
      @(negedge clk_i);
      start_i = 1'b0; key_len_i = 2'd0; #1;
      n_checks++; if ({err_o, busy_o, ks_start_o} !== 3'b100) begin n_fail++; $display("FAIL illegal err/busy/ks got %b exp 100", {err_o, busy_o, ks_start_o}); end
      @(negedge clk_i); #1;
      n_checks++; if ({err_o, busy_o, ks_start_o} !== 3'b000) begin n_fail++; $display("FAIL illegal_after got %b exp 000", {err_o, busy_o, ks_start_o}); end
      @(negedge clk_i);
      start_i = 1'b1; n_blocks_i = '0;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk_i);
         start_i = 1'b0; #1;
         if (done_o === 1'b1) dones++;
         if (ks_start_o === 1'b1) ks++;
      end
      n_checks++; if (dones !== 1) begin n_fail++; $display("FAIL empty_job done_pulses got %0d exp 1", dones); end
      n_checks++; if (ks !== 0) begin n_fail++; $display("FAIL empty_job ks_start got %0d exp 0", ks); end
      n_checks++; if ({busy_o, blk_cnt_o} !== {1'b0, 16'd0}) begin n_fail++; $display("FAIL empty_job end busy=%b cnt=%0d exp 0/0", busy_o, blk_cnt_o); end
   endtask

   task automatic test_clear();
      int dones = 0;
      run_job(2'd0, 1'b0, 2, 1, 0, -1, 0, 5, 0, 1'b0, "clear");
      for (int c = 0; c < 4; c++) begin
         @(negedge clk_i); #1;
         if (done_o === 1'b1 || busy_o === 1'b1) dones++;
      end
      n_checks++; if (dones !== 0) begin n_fail++; $display("FAIL clear idle_after got %0d busy/done cycles exp 0", dones); end
      run_job(2'd0, 1'b1, 1, 1, 0, -1, 0, 0, 0, 1'b0, "after_clear");
   endtask

   task automatic test_reset_mid_output();
      run_job(2'd1, 1'b0, 2, 0, 0, 0, 2, 0, 3, 1'b1, "rst_mid");
      run_job(2'd2, 1'b0, 1, 0, 1, -1, 0, 0, 0, 1'b0, "after_rst");
   endtask

   task automatic test_back_to_back();
      run_job(2'd0, 1'b1, 4, 3, 0, 2, 1, 0, 0, 1'b0, "b2b");
   endtask

   initial begin
      test_reset();
      test_aes128();
      test_aes256_stall();
      test_aes192_delay();
      test_illegal_and_empty();
      test_clear();
      test_reset_mid_output();
      test_back_to_back();
      n_checks++; if (sb.size() != 0) begin n_fail++; $display("FAIL scoreboard_leftover got %0d exp 0", sb.size()); end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
